mem_port_requester: RTL and testbench



---
 rtl/mem_port_requester.sv | 120 ++++++++++++
 tb/tb_mem_port_requester.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_requester.sv
// Request front-end for a fixed-latency single-port memory: read credit control,
// write-after-read hazard stalls, and an in-order response FIFO.
module mem_port_requester #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1,
  parameter int unsigned RSP_DEPTH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0]      i_req_wdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_din,
  input  logic [WIDTH-1:0]      i_mem_dout,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_data
);

  localparam int unsigned PIPE_LEN = READ_LATENCY + 1;
  localparam int unsigned HAZ_LEN  = WRITE_LATENCY + 1;
  localparam int unsigned PTR_W    = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned OUT_W    = $clog2(RSP_DEPTH + PIPE_LEN) + 1;

  logic [PIPE_LEN-1:0]                rd_pipe_q, rd_pipe_d;
  logic [HAZ_LEN-1:0]                 haz_vld_q, haz_vld_d;
  logic [HAZ_LEN-1:0][ADDR_WIDTH-1:0] haz_addr_q, haz_addr_d;
  logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic [WIDTH-1:0]                   mem_q [RSP_DEPTH];

  logic             hazard_c;
  logic             credit_ok_c;
  logic             req_ready_c;
  logic             issue_c;
  logic             rd_issue_c;
  logic             wr_issue_c;
  logic             push_c;
  logic             pop_c;
  logic [OUT_W-1:0] outstanding_c;

  // Acceptance: writes always go; reads need a free response slot and no pending write to the same address.
  // A pop in this cycle frees its slot immediately so a steady read stream runs at full rate.
  always_comb begin
    hazard_c      = 1'b0;
    outstanding_c = OUT_W'(count_q);
    for (int i = 0; i < int'(HAZ_LEN); i++) begin
      if (haz_vld_q[i] && (haz_addr_q[i] == i_req_addr)) hazard_c = 1'b1;
    end
    for (int i = 0; i < int'(PIPE_LEN); i++) begin
      outstanding_c = outstanding_c + OUT_W'(rd_pipe_q[i]);
    end
    pop_c       = (count_q != '0) && i_rsp_ready;
    push_c      = rd_pipe_q[PIPE_LEN-1];
    credit_ok_c = (outstanding_c - OUT_W'(pop_c)) < OUT_W'(RSP_DEPTH);
    req_ready_c = i_rst_n && (i_req_we || (!hazard_c && credit_ok_c));
    issue_c     = i_req_valid && req_ready_c;
    rd_issue_c  = issue_c && !i_req_we;
    wr_issue_c  = issue_c && i_req_we;
  end

  // Read-valid pipeline, write hazard window and FIFO bookkeeping.
  always_comb begin
    rd_pipe_d  = {rd_pipe_q[PIPE_LEN-2:0], rd_issue_c};
    haz_vld_d  = '0;
    haz_addr_d = '0;
    haz_vld_d[0]  = wr_issue_c;
    haz_addr_d[0] = wr_issue_c ? i_req_addr : '0;
    for (int i = 1; i < int'(HAZ_LEN); i++) begin
      haz_vld_d[i]  = haz_vld_q[i-1];
      haz_addr_d[i] = haz_addr_q[i-1];
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_pipe_q  <= '0;
      haz_vld_q  <= '0;
      haz_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      haz_vld_q  <= haz_vld_d;
      haz_addr_q <= haz_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; only entries below the occupancy count are ever observed.
  always_ff @(posedge i_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= i_mem_dout;
  end

  always_comb begin
    o_req_ready = req_ready_c;
    o_mem_en    = issue_c;
    o_mem_we    = wr_issue_c;
    o_mem_addr  = issue_c ? i_req_addr : '0;
    o_mem_din   = issue_c ? i_req_wdata : '0;
    o_rsp_valid = (count_q != '0);
    o_rsp_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_mem_port_requester.sv
// Scoreboard bench for mem_port_requester with a fixed-latency memory model.
module tb_mem_port_requester;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int WL = 1;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid, o_req_ready, i_req_we;
  logic [AW-1:0] i_req_addr;
  logic [W-1:0]  i_req_wdata;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [W-1:0]  o_mem_din;
  logic [W-1:0]  i_mem_dout = '0;
  logic          o_rsp_valid, i_rsp_ready;
  logic [W-1:0]  o_rsp_data;

  always #5 clk = ~clk;

  mem_port_requester #(
    .WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .RSP_DEPTH(D)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
    .i_mem_dout(i_mem_dout),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: data for a read sampled at edge e_t appears after edge e_{t+RL} and is held.
  logic [W-1:0] mem_model [16];
  logic         rd_v [RL];
  logic [W-1:0] rd_d [RL];
  initial for (int i = 0; i < RL; i++) rd_v[i] = 1'b0;

  always @(posedge clk) begin
    rd_v[0] <= o_mem_en && !o_mem_we;
    rd_d[0] <= mem_model[o_mem_addr];
    for (int i = 1; i < RL; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_d[i] <= rd_d[i-1];
    end
    if (rd_v[RL-1]) i_mem_dout <= rd_d[RL-1];
    if (o_mem_en && o_mem_we) mem_model[o_mem_addr] <= o_mem_din;
  end

  logic [W-1:0] exp_mem [16];
  logic [W-1:0] exp_q [$];
  int  cyc = 0;
  int  issue_cyc = 0;
  int  pops = 0;
  bit  stream_on = 1'b0;
  bit  rand_pop = 1'b0;
  int  prev_pop = -1;
  int  gaps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid && i_rsp_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_data", 32'(o_rsp_data), 32'(exp_q.pop_front()));
      if (stream_on) begin
        if (prev_pop >= 0 && (cyc - prev_pop) != 1) gaps++;
        prev_pop = cyc;
      end
    end
  end

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                        output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = a;
    i_req_wdata = d;
    if (rand_pop) i_rsp_ready = 1'($urandom_range(0, 1));
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (o_req_ready) begin
        done      = 1'b1;
        issue_cyc = cyc;
        chk("mem_en", 32'(o_mem_en), 32'd1);
        chk("mem_addr", 32'(o_mem_addr), 32'(a));
        if (we) begin
          chk("mem_din", 32'(o_mem_din), 32'(d));
          exp_mem[a] = d;
        end else begin
          exp_q.push_back(exp_mem[a]);
        end
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (rand_pop) i_rsp_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("req_timeout", 32'd0, 32'd1);
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_wdata = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
      if (rand_pop) i_rsp_ready = 1'($urandom_range(0, 1));
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int st;
    int tot;
    int cnt;
    int pops0;
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = '0;
    i_req_wdata = 8'h40;
    i_rsp_ready = 1'b0;

    // Reset behaviour with a request already pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(o_rsp_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload all addresses; the first write must go in the first cycle.
    do_req(1'b1, 4'd0, 8'h40, st);
    chk("first_req_stall", 32'(st), 32'd0);
    for (int a = 1; a < 16; a++) do_req(1'b1, AW'(a), W'(8'h40 + a * 7), st);
    @(negedge clk);
    chk("idle_mem_en", 32'(o_mem_en), 32'd0);
    chk("idle_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("idle_mem_din", 32'(o_mem_din), 32'd0);
    @(posedge clk);
    #1 i_rsp_ready = 1'b1;

    // Read right after a write to the same address.
    do_req(1'b1, 4'd3, 8'hA5, st);
    do_req(1'b0, 4'd3, 8'h00, st);
    chk("haz_stall", 32'(st), 32'd2);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_rsp_valid) break;
    end
    chk("rd_latency", 32'(cyc - issue_cyc), 32'd4);
    chk("haz_rsp_data", 32'(o_rsp_data), 32'hA5);
    drain();

    // Write then read of a different address.
    do_req(1'b1, 4'd7, 8'h77, st);
    do_req(1'b0, 4'd8, 8'h00, st);
    chk("nohaz_stall", 32'(st), 32'd0);
    drain();

    // Credit limit with responses held back.
    i_rsp_ready = 1'b0;
    tot = 0;
    for (int a = 0; a < 4; a++) begin
      do_req(1'b0, AW'(a), 8'h00, st);
      tot += st;
    end
    chk("credit_stalls", 32'(tot), 32'd0);
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 4'd4;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_req_ready) cnt++;
    end
    chk("full_ready", 32'(cnt), 32'd0);
    chk("full_rsp_valid", 32'(o_rsp_valid), 32'd1);
    @(posedge clk);
    #1 i_rsp_ready = 1'b1;
    do_req(1'b0, 4'd4, 8'h00, st);
    do_req(1'b0, 4'd5, 8'h00, st);
    drain();

    // Streaming reads.
    stream_on = 1'b1;
    prev_pop  = -1;
    gaps      = 0;
    tot       = 0;
    for (int a = 0; a < 12; a++) begin
      do_req(1'b0, AW'(a), 8'h00, st);
      tot += st;
    end
    chk("stream_stalls", 32'(tot), 32'd0);
    drain();
    stream_on = 1'b0;
    chk("stream_gaps", 32'(gaps), 32'd0);

    // Pointer wrap with random pop back-pressure.
    pops0    = pops;
    rand_pop = 1'b1;
    for (int k = 0; k < 10; k++) do_req(1'b0, AW'(k * 5 + 2), 8'h00, st);
    drain();
    rand_pop    = 1'b0;
    i_rsp_ready = 1'b1;
    chk("wrap_pops", 32'(pops - pops0), 32'd10);

    // Reset with reads in flight.
    i_rsp_ready = 1'b0;
    do_req(1'b0, 4'd1, 8'h00, st);
    do_req(1'b0, 4'd2, 8'h00, st);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_rsp_valid) break;
    end
    chk("pre_rst_valid", 32'(o_rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("mid_rst_data", 32'(o_rsp_data), 32'd0);
    chk("mid_rst_ready", 32'(o_req_ready), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i_rsp_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_rsp_valid) cnt++;
    end
    chk("post_rst_rsp", 32'(cnt), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
